// File: rtl/commit_monitor_pkg.sv
// Shared types and helpers for the commit-stream end-of-run / hang monitor.
package commit_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int POP_W = 64;

    function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/commit_monitor_progress.sv
// Oldest-break priority encode, accepted-port mask, last-PC tracking and stall timer.
module commit_monitor_progress #(
    parameter int NUM_PORTS   = 1,
    parameter int XLEN        = 32,
    parameter int STALL_LIMIT = 100
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run,
    input  logic [NUM_PORTS-1:0]      cmt_valid,
    input  logic [NUM_PORTS*XLEN-1:0] cmt_pc,
    input  logic [NUM_PORTS-1:0]      cmt_break,
    output logic                      brk_hit,
    output logic [NUM_PORTS-1:0]      brk_valid_mask,
    output logic                      stall_expire,
    output logic [XLEN-1:0]           last_pc
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_TC = SW'(STALL_LIMIT - 1);

    logic [SW-1:0]   stall_cnt;
    logic            have_pc;
    logic            progress;
    logic            any_acc;
    logic [XLEN-1:0] young_pc;

    // Walk ports oldest-first; everything younger than the first break is dropped.
    always_comb begin
        brk_hit        = 1'b0;
        brk_valid_mask = '0;
        progress       = 1'b0;
        any_acc        = 1'b0;
        young_pc       = last_pc;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!brk_hit) begin
                brk_valid_mask[k] = cmt_valid[k];
                if (cmt_valid[k]) begin
                    any_acc  = 1'b1;
                    young_pc = cmt_pc[k*XLEN +: XLEN];
                    if (!have_pc || (cmt_pc[k*XLEN +: XLEN] != last_pc)) begin
                        progress = 1'b1;
                    end
                    if (cmt_break[k]) begin
                        brk_hit = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_expire = run && !progress && (stall_cnt == STALL_TC);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            have_pc   <= 1'b0;
            last_pc   <= '0;
        end else if (!run) begin
            stall_cnt <= '0;
            have_pc   <= 1'b0;
            last_pc   <= '0;
        end else begin
            if (any_acc) begin
                last_pc <= young_pc;
                have_pc <= 1'b1;
            end
            if (progress) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_TC) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/commit_monitor.sv
// Commit-stream monitor: ebreak verdict, stall timeout and delayed finish pulse.
// Optional retired-instruction counter is enabled by defining COMMIT_MONITOR_INSTRET_EN.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int NUM_PORTS    = 1,
    parameter int XLEN         = 32,
    parameter int STALL_LIMIT  = 100,
    parameter int DRAIN_CYCLES = 10,
    parameter int CNT_W        = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      arm_i,
    input  logic [NUM_PORTS-1:0]      cmt_valid_i,
    input  logic [NUM_PORTS*XLEN-1:0] cmt_pc_i,
    input  logic [NUM_PORTS-1:0]      cmt_break_i,
    input  logic [XLEN-1:0]           a0_i,
    output logic                      halted_o,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic                      timeout_o,
    output logic [XLEN-1:0]           exit_code_o,
    output logic [XLEN-1:0]           stuck_pc_o,
    output logic [CNT_W-1:0]          cycle_o,
    output logic [CNT_W-1:0]          instret_o,
    output logic                      finish_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t                 state, state_d;
    logic                   run;
    logic                   brk_hit;
    logic                   stall_expire;
    logic [NUM_PORTS-1:0]   acc_mask;
    logic [XLEN-1:0]        last_pc;
    logic [DW-1:0]          drain_cnt;
    logic                   do_break, do_timeout, finish_d;

    assign run = (state == ST_RUN);

    commit_monitor_progress #(
        .NUM_PORTS  (NUM_PORTS),
        .XLEN       (XLEN),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_progress (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .cmt_valid     (cmt_valid_i),
        .cmt_pc        (cmt_pc_i),
        .cmt_break     (cmt_break_i),
        .brk_hit       (brk_hit),
        .brk_valid_mask(acc_mask),
        .stall_expire  (stall_expire),
        .last_pc       (last_pc)
    );

    always_comb begin
        state_d    = state;
        do_break   = 1'b0;
        do_timeout = 1'b0;
        finish_d   = 1'b0;
        case (state)
            ST_IDLE: if (arm_i) state_d = ST_RUN;
            ST_RUN: begin
                // A break in the expiring cycle takes the break verdict.
                if (brk_hit || stall_expire) begin
                    do_break   = brk_hit;
                    do_timeout = !brk_hit;
                    if (DRAIN_CYCLES == 0) begin
                        state_d  = ST_DONE;
                        finish_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d  = ST_DONE;
                    finish_d = 1'b1;
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            finish_o    <= 1'b0;
            halted_o    <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
            exit_code_o <= '0;
            stuck_pc_o  <= '0;
            cycle_o     <= '0;
            drain_cnt   <= '0;
        end else begin
            state    <= state_d;
            finish_o <= finish_d;
            if (run && (cycle_o != '1)) cycle_o <= cycle_o + 1'b1;
            if (do_break) begin
                halted_o    <= 1'b1;
                exit_code_o <= a0_i;
                pass_o      <= (a0_i == '0);
                fail_o      <= (a0_i != '0);
            end
            if (do_timeout) begin
                halted_o   <= 1'b1;
                timeout_o  <= 1'b1;
                stuck_pc_o <= last_pc;
            end
            if (run) drain_cnt <= DRAIN_LOAD;
            else if (state == ST_DRAIN) drain_cnt <= drain_cnt - 1'b1;
        end
    end

`ifdef COMMIT_MONITOR_INSTRET_EN
    logic [CNT_W:0] ins_sum;
    assign ins_sum = {1'b0, instret_o} + (CNT_W+1)'(popcount(POP_W'(acc_mask)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) instret_o <= '0;
        else if (run) instret_o <= ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];
    end
`else
    logic unused_acc;
    assign unused_acc = ^acc_mask;
    assign instret_o  = '0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Randomized + directed bench for commit_monitor: a 2-port/limit-100/drain-10 instance
// and a 1-port/limit-7/drain-0 instance, both compared every cycle to a behavioural model.
module tb_commit_monitor;

    localparam int LIM2 = 100, DRN2 = 10;
    localparam int LIM1 = 7,   DRN1 = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        arm;
    logic [1:0]  v2, b2;
    logic [63:0] pc2;
    logic [31:0] a0;

    logic        halted2, pass2, fail2, tmo2, fin2;
    logic [31:0] exit2, stuck2, cyc2, ins2;
    logic        halted1, pass1, fail1, tmo1, fin1;
    logic [31:0] exit1, stuck1, cyc1, ins1;

    commit_monitor #(.NUM_PORTS(2), .XLEN(32), .STALL_LIMIT(LIM2), .DRAIN_CYCLES(DRN2), .CNT_W(32)) dut2 (
        .clock(clock), .reset(reset), .arm_i(arm), .cmt_valid_i(v2), .cmt_pc_i(pc2),
        .cmt_break_i(b2), .a0_i(a0), .halted_o(halted2), .pass_o(pass2), .fail_o(fail2),
        .timeout_o(tmo2), .exit_code_o(exit2), .stuck_pc_o(stuck2), .cycle_o(cyc2),
        .instret_o(ins2), .finish_o(fin2));

    commit_monitor #(.NUM_PORTS(1), .XLEN(32), .STALL_LIMIT(LIM1), .DRAIN_CYCLES(DRN1), .CNT_W(32)) dut1 (
        .clock(clock), .reset(reset), .arm_i(arm), .cmt_valid_i(v2[0]), .cmt_pc_i(pc2[31:0]),
        .cmt_break_i(b2[0]), .a0_i(a0), .halted_o(halted1), .pass_o(pass1), .fail_o(fail1),
        .timeout_o(tmo1), .exit_code_o(exit1), .stuck_pc_o(stuck1), .cycle_o(cyc1),
        .instret_o(ins1), .finish_o(fin1));

    // phase: 0 idle, 1 monitoring, 2 draining, 3 finished
    typedef struct {
        int          phase;
        bit          has_pc;
        logic [31:0] last_pc;
        int          stall;
        int          drain_left;
        bit          halted, pass, fail, tmo, finish;
        logic [31:0] exit_code, stuck, cycle, instret;
    } mdl_t;

    mdl_t m1, m2;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tb_cyc   = 0;
    int   halt_at, fin_at, fin_cnt;
    bit   halt_seen;

    function automatic mdl_t mdl_clear();
        mdl_t z;
        z.phase = 0; z.has_pc = 0; z.last_pc = '0; z.stall = 0; z.drain_left = 0;
        z.halted = 0; z.pass = 0; z.fail = 0; z.tmo = 0; z.finish = 0;
        z.exit_code = '0; z.stuck = '0; z.cycle = '0; z.instret = '0;
        return z;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, int np, int lim, int drn, bit arm_in,
                                      bit [1:0] v, bit [63:0] pc, bit [1:0] br, logic [31:0] a0_in);
        mdl_t        n;
        int          oldest;
        int          cnt;
        bit          prog;
        bit          stop;
        logic [31:0] p;
        n = m;
        n.finish = 0;
        stop = 0;
        oldest = np;
        cnt = 0;
        prog = 0;
        case (m.phase)
            0: if (arm_in) begin
                n.phase = 1; n.has_pc = 0; n.stall = 0;
            end
            1: begin
                if (m.cycle != 32'hFFFF_FFFF) n.cycle = m.cycle + 1;
                for (int k = np - 1; k >= 0; k--) if (v[k] && br[k]) oldest = k;
                for (int k = 0; k < np; k++) begin
                    if (k <= oldest && v[k]) begin
                        p = pc[k*32 +: 32];
                        cnt++;
                        if (!m.has_pc || p != m.last_pc) prog = 1;
                        n.last_pc = p;
                        n.has_pc = 1;
                    end
                end
                n.instret = m.instret + cnt;
                if (oldest < np) begin
                    n.halted = 1; n.exit_code = a0_in;
                    n.pass = (a0_in == 0); n.fail = (a0_in != 0);
                    stop = 1;
                end else if (prog) begin
                    n.stall = 0;
                end else begin
                    n.stall = m.stall + 1;
                    if (n.stall == lim) begin
                        n.halted = 1; n.tmo = 1; n.stuck = m.last_pc;
                        stop = 1;
                    end
                end
                if (stop) begin
                    if (drn == 0) begin n.phase = 3; n.finish = 1; end
                    else begin n.phase = 2; n.drain_left = drn; end
                end
            end
            2: begin
                n.drain_left = m.drain_left - 1;
                if (n.drain_left == 0) begin n.phase = 3; n.finish = 1; end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (tb cycle %0d)", tag, got, exp, tb_cyc);
    endtask

    task automatic compare_all();
        logic [31:0] e_ins2, e_ins1;
`ifdef COMMIT_MONITOR_INSTRET_EN
        e_ins2 = m2.instret; e_ins1 = m1.instret;
`else
        e_ins2 = '0; e_ins1 = '0;
`endif
        check("d2_halted", halted2, m2.halted);
        check("d2_pass",   pass2,   m2.pass);
        check("d2_fail",   fail2,   m2.fail);
        check("d2_tmo",    tmo2,    m2.tmo);
        check("d2_exit",   exit2,   m2.exit_code);
        check("d2_stuck",  stuck2,  m2.stuck);
        check("d2_cycle",  cyc2,    m2.cycle);
        check("d2_instret", ins2,   e_ins2);
        check("d2_finish", fin2,    m2.finish);
        check("d1_halted", halted1, m1.halted);
        check("d1_pass",   pass1,   m1.pass);
        check("d1_fail",   fail1,   m1.fail);
        check("d1_tmo",    tmo1,    m1.tmo);
        check("d1_exit",   exit1,   m1.exit_code);
        check("d1_stuck",  stuck1,  m1.stuck);
        check("d1_cycle",  cyc1,    m1.cycle);
        check("d1_instret", ins1,   e_ins1);
        check("d1_finish", fin1,    m1.finish);
    endtask

    task automatic tick();
        @(posedge clock);
        m2 = mdl_step(m2, 2, LIM2, DRN2, arm, v2, pc2, b2, a0);
        m1 = mdl_step(m1, 1, LIM1, DRN1, arm, {1'b0, v2[0]}, {32'b0, pc2[31:0]}, {1'b0, b2[0]}, a0);
        #1;
        tb_cyc++;
        compare_all();
        if (halted2 && !halt_seen) begin halt_seen = 1; halt_at = tb_cyc; end
        if (fin2) begin fin_at = tb_cyc; fin_cnt++; end
    endtask

    task automatic set_idle();
        arm = 0; v2 = '0; b2 = '0; pc2 = '0; a0 = '0;
    endtask

    // Called just after a checked edge; the reset pulse ends before the next edge.
    task automatic apply_reset();
        reset = 1'b0;
        #2;
        check("rst_halted", {halted2, halted1}, 0);
        check("rst_verdict", {pass2, fail2, tmo2, pass1, fail1, tmo1}, 0);
        check("rst_fin", {fin2, fin1}, 0);
        check("rst_words", {exit2 | stuck2 | cyc2 | ins2, exit1 | stuck1 | cyc1 | ins1}, 0);
        m1 = mdl_clear();
        m2 = mdl_clear();
        halt_seen = 0; halt_at = 0; fin_at = 0; fin_cnt = 0;
        set_idle();
        reset = 1'b1;
    endtask

    task automatic arm_run();
        arm = 1; tick(); arm = 0;
    endtask

    task automatic commit0(input logic [31:0] pc, input bit brk, input logic [31:0] a0v);
        v2 = 2'b01; b2 = {1'b0, brk}; pc2 = {32'b0, pc}; a0 = a0v;
        tick();
    endtask

    // Drive junk while draining; outputs must hold until the finish pulse.
    task automatic run_to_done(input int bound, input bit must_finish);
        int i;
        i = 0;
        while (i < bound && !(m2.phase == 3 && m1.phase == 3 && fin_cnt > 0)) begin
            arm = 1'($urandom); v2 = 2'($urandom); b2 = 2'($urandom);
            pc2 = {$urandom, $urandom}; a0 = $urandom;
            tick();
            i++;
        end
        for (int k = 0; k < 3; k++) tick();
        if (must_finish) check("finish_seen", fin_cnt, 1);
        set_idle();
    endtask

    task automatic pass_fail_seq(input logic [31:0] a0v);
        arm_run();
        for (int i = 0; i < 4; i++) commit0(32'h8000_0000 + 32'(4 * i), 0, 0);
        commit0(32'h8000_0010, 1, a0v);
        set_idle();
        run_to_done(40, 1);
        check("seq_drain_gap", fin_at - halt_at, DRN2);
        check("seq_cycle", cyc2, 5);
`ifdef COMMIT_MONITOR_INSTRET_EN
        check("seq_instret", ins2, 5);
`endif
    endtask

    initial begin
        int cnt;
        int mode;
        set_idle();
        m1 = mdl_clear(); m2 = mdl_clear();
        halt_seen = 0; fin_cnt = 0; halt_at = 0; fin_at = 0;
        #2;
        check("por_halted", {halted2, halted1}, 0);
        check("por_fin", {fin2, fin1}, 0);
        #1 reset = 1'b1;
        tick();

        // PASS
        pass_fail_seq(32'h0);
        check("pass_verdict", {pass2, fail2, tmo2}, 3'b100);
        check("pass_exit", exit2, 0);
        apply_reset();

        // FAIL
        pass_fail_seq(32'h3);
        check("fail_verdict", {pass2, fail2, tmo2}, 3'b010);
        check("fail_exit", exit2, 3);
        apply_reset();

        // Self-loop hang
        arm_run();
        cnt = 0;
        while (!halted2 && cnt < 300) begin
            commit0(32'h8000_0100, 0, 0);
            cnt++;
        end
        set_idle();
        check("hang_latency", cnt, LIM2 + 1);
        check("hang_verdict", {pass2, fail2, tmo2}, 3'b001);
        check("hang_stuck_pc", stuck2, 32'h8000_0100);
        run_to_done(40, 1);
        apply_reset();

        // Dual-port ordering
        arm_run();
        commit0(32'h8000_01FC, 0, 0);
        v2 = 2'b11; b2 = 2'b01; pc2 = {32'h8000_0204, 32'h8000_0200}; a0 = 0;
        tick();
        set_idle();
        check("dual_verdict", {pass2, fail2, tmo2}, 3'b100);
`ifdef COMMIT_MONITOR_INSTRET_EN
        check("dual_instret", ins2, 2);
`endif
        run_to_done(40, 1);
        apply_reset();

        // Break in the exact cycle the timeout would fire
        arm_run();
        for (int i = 0; i < LIM2 - 1; i++) tick();
        check("prio_not_yet", halted2, 0);
        commit0(32'h8000_0300, 1, 0);
        set_idle();
        check("prio_verdict", {pass2, fail2, tmo2}, 3'b100);
        run_to_done(40, 1);
        apply_reset();

        // Reset mid-drain, then re-arm
        arm_run();
        commit0(32'h8000_0400, 1, 32'h5);
        set_idle();
        for (int i = 0; i < 3; i++) tick();
        check("mid_drain_state", halted2 & ~fin2, 1);
        apply_reset();
        for (int i = 0; i < DRN2 + 3; i++) tick();
        check("no_fin_after_rst", fin_cnt, 0);
        pass_fail_seq(32'h0);
        check("rearm_verdict", {pass2, fail2, tmo2}, 3'b100);
        apply_reset();

        // Randomized episodes
        for (int e = 0; e < 24; e++) begin
            mode = e % 3;
            cnt = 0;
            while (m2.phase != 3 && cnt < 400) begin
                arm = ($urandom_range(0, 3) == 0);
                if (mode == 1) begin
                    v2 = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
                    pc2 = {32'h8000_0800, 32'h8000_0800};
                end else begin
                    v2 = 2'($urandom);
                    pc2 = {32'h8000_0000 + 32'(4 * $urandom_range(0, 3)),
                           32'h8000_0000 + 32'(4 * $urandom_range(0, 3))};
                end
                b2[0] = (mode != 2) && ($urandom_range(0, 39) == 0);
                b2[1] = (mode != 2) && ($urandom_range(0, 39) == 0);
                a0 = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
                tick();
                cnt++;
            end
            set_idle();
            run_to_done(20, 0);
            apply_reset();
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Synthesizable end-of-run and hang monitor for the NPC commit stream, generalised to N commit ports. It watches retiring instructions and latches the `ebreak` exit code, deciding PASS when a0 == 0 and FAIL otherwise. It also detects a stalled core: no forward PC progress for a programmable number of cycles. After a drain delay it raises a single finish pulse, so both FPGA/ASIC bring-up and the simulation top can stop on one signal.

## Interface
- `NUM_PORTS`, 1: commit ports; port 0 is oldest in program order.
- `XLEN`, 32: PC/data width.
- `STALL_LIMIT`, 100: consecutive non-progress cycles that trigger a timeout; must be ≥ 1.
- `DRAIN_CYCLES`, 10: cycles between halt and `finish_o`; 0 is allowed.
- `CNT_W`, 32: width of the cycle and instret counters.
- `clock`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low.
- `arm_i`, in, 1: starts monitoring; sampled only in IDLE.
- `cmt_valid_i`, in, NUM_PORTS: per-port retire strobe.
- `cmt_pc_i`, in, NUM_PORTS*XLEN: per-port retired PC; port k occupies bits [k*XLEN +: XLEN].
- `cmt_break_i`, in, NUM_PORTS: the retiring instruction is `ebreak`.
- `a0_i`, in, XLEN: architectural x10 as seen by the oldest break this cycle.
- `halted_o`, out, 1: a break or timeout has been latched.
- `pass_o`, `fail_o`, `timeout_o`, out, 1 each: verdict; at most one is ever high.
- `exit_code_o`, out, XLEN: latched a0.
- `stuck_pc_o`, out, XLEN: last progress PC, latched on timeout.
- `cycle_o`, out, CNT_W: cycles spent in RUN.
- `instret_o`, out, CNT_W: retired instruction count; present only with the macro.
- `finish_o`, out, 1: single-cycle pulse.

## Operation
- **States:** IDLE → RUN → DRAIN → DONE.
- **IDLE:**
  - When `arm_i` is high, go to RUN next edge.
  - In RUN, `arm_i` is ignored; arming is sticky.
- **Oldest break:** the lowest valid port with its break bit set. Ports younger than it are ignored this cycle for all counting and PC tracking.
- **Progress:** an accepted commit whose PC ≠ `last_pc`.
  - The first accepted commit after arming always counts as progress.
  - `last_pc` takes the PC of the youngest accepted port.
- **Stall counter:**
  - Cleared on any progress cycle; otherwise increments.
  - Counts from RUN entry even before any commit, so a core that never starts is caught.
- **RUN break:**
  - Latch `exit_code_o = a0_i`.
  - Set `pass_o` if a0_i == 0, else `fail_o`.
  - Go to DRAIN.
- **RUN timeout:** a cycle that is not progress, with stall count == STALL_LIMIT−1.
  - Set `timeout_o`.
  - Latch `stuck_pc_o = last_pc`.
  - Go to DRAIN.
- **Break and timeout in the same cycle:** break wins. A break is a commit, but the verdict is still the break verdict.
- **DRAIN:** counts DRAIN_CYCLES, then pulses `finish_o` and enters DONE. DONE is absorbing; only reset leaves it.
- **Counters:**
  - `cycle_o` increments every RUN cycle and saturates at all-ones.
  - In DRAIN/DONE all inputs are ignored and verdict outputs hold.

## Timing
- **Reset values:** all outputs 0 and state IDLE.
- **Reset mid-run:** clears everything asynchronously, including latched verdicts.
- **Output registration:** all outputs are registered.
- **Break latency:** break in cycle N → `halted_o`, verdict and `exit_code_o` valid from N+1.
- **Finish latency:** `finish_o` is high in cycle N+1+DRAIN_CYCLES.
- **DRAIN_CYCLES = 0:** `finish_o` rises together with `halted_o` at N+1.
- **Timeout latency:** `timeout_o` rises the cycle after the STALL_LIMIT-th consecutive non-progress RUN cycle.
- **Port update:** `cycle_o` and `instret_o` update one cycle after the qualifying event.

## Configuration
- **`COMMIT_MONITOR_INSTRET_EN` defined:**
  - Add a CNT_W saturating counter that adds the popcount of accepted valid ports each RUN cycle.
  - The break instruction itself is counted; younger ports are not.
- **Macro undefined:** `instret_o` is tied to 0 and no counter or popcount logic is generated.

## Structure
- **Package `commit_monitor_pkg`:** holds the state enum (IDLE/RUN/DRAIN/DONE) and a `popcount` function.
- **Sub-module `commit_monitor_progress`:**
  - Contains the oldest-break priority encoder, accepted-port mask, `last_pc` register and stall counter.
  - Counter width is $clog2(STALL_LIMIT+1).
  - Outputs `brk_hit`, `brk_valid_mask` and `stall_expire`.
- **Top:** FSM, latches, cycle/instret counters and drain counter.

## Test plan
- **Single-port PASS:** NUM_PORTS=1, arm, commit PCs 0x80000000..0x8000000C, then break with a0=0 → `pass_o`=1, `exit_code_o`=0; `finish_o` pulses exactly 10 cycles after `halted_o`; `instret_o`=5 with the macro.
- **FAIL:** same sequence with a0=0x3 → `fail_o`=1, `pass_o`=0, `exit_code_o`=0x3.
- **Self-loop hang:** PC repeatedly 0x80000100, STALL_LIMIT=100 → `timeout_o` rises on the 101st cycle after the last progress; `stuck_pc_o`=0x80000100; `pass_o`=`fail_o`=0.
- **Dual-port ordering:** NUM_PORTS=2, port0 break with a0=0 and port1 valid with PC 0x80000204 in the same cycle → PASS; port1 excluded from instret and `last_pc`.
- **Priority and drain:** break arrives in the exact cycle the timeout would fire → PASS, `timeout_o`=0. Separately, DRAIN_CYCLES=0 gives `finish_o` coincident with `halted_o`.
- **Reset mid-DRAIN:** assert reset during DRAIN → all outputs 0 immediately; no `finish_o` pulse; re-arm works normally.
